// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the bus arbiter slice.
// Contents:
//   NUM_MASTERS   default master count
//   htrans_e      transfer type encoding
//   hburst_e      burst type encoding
//   hresp_e       slave response encoding
//   burst_beats() beats in a fixed-length burst (1 for SINGLE and undefined-length INCR)
package ahb_pkg;

  localparam int NUM_MASTERS = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // INCR has no defined length, so it is treated like SINGLE: no grant hold.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin request picker.
// Ports:
//   req    in  N   request vector (already masked for eligibility)
//   ptr    in  IW  index where the search starts
//   gnt    out N   one-hot winner, all zero when nothing is requested
//   idx    out IW  index of the winner
//   valid  out 1   at least one request was present
module ahb_rr_picker #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam int CW = IW + 1;

  // ptr < N and offset < N, so one conditional subtract gives the modulo.
  logic [CW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst hold, locked transfers and
// SPLIT masking.
// Ports:
//   hclk, hrst         clock, synchronous active-high reset
//   hbusreq, hlock     per-master request / locked-access request
//   htrans, hburst     current address-phase transfer and burst type
//   hready, hresp      bus ready and slave response
//   hsplit             per-master split resume
//   hgrant             registered one-hot grant
//   hmaster, hmastlock registered address-phase owner and lock flag
//
// state  | meaning
// ARB    | arbitrate at every hready edge
// BURST  | fixed-length burst in progress, grant held until the last beat
// LOCKED | owner holds hlock, grant held until it drops
module ahb_arbiter #(
  parameter int NUM_MASTERS    = ahb_pkg::NUM_MASTERS,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  import ahb_pkg::*;

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} arb_state_e;

  arb_state_e state_q, state_d;
  logic [3:0]             rem_q, rem_d, rem_load, rem_dec;
  logic [NUM_MASTERS-1:0] split_q, split_d, split_set;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d, rr_ptr;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   resp_first, arb;

  assign rr_ptr = (last_q == IW'(NUM_MASTERS - 1)) ? '0 : last_q + IW'(1);

  ahb_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req   (hbusreq & ~split_q),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // First cycle of a two-cycle response: hready low with a non-OKAY response.
  assign resp_first = !hready && (hresp != HRESP_OKAY);
  assign split_set  = (resp_first && hresp == HRESP_SPLIT)
                      ? (NUM_MASTERS'(1) << hmaster) : '0;
  // Set is ORed in after the clear so a simultaneous set wins.
  assign split_d    = (split_q & ~hsplit) | split_set;
  assign rem_load   = 4'(burst_beats(hburst) - 5'd1);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rem_dec = rem_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = hgrant;
    arb     = 1'b0;
    if (resp_first) begin
      rem_d = '0;
      if (state_q != ST_LOCKED || hresp == HRESP_SPLIT || hresp == HRESP_RETRY)
        state_d = ST_ARB;
    end else if (hready) begin
      case (state_q)
        ST_BURST: begin
          if (rem_q == '0) begin
            arb = 1'b1;
          end else begin
            if (htrans == HTRANS_SEQ) rem_dec = rem_q - 4'd1;
            rem_d = rem_dec;
            // Releasing one beat early puts the new grant on the last address phase.
            if (rem_dec <= 4'd1) arb = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!hlock[owner_q]) state_d = ST_ARB;
        end
        default: begin
          // Burst start keeps the current grant instead of re-arbitrating.
          if (!hlock[owner_q] && htrans == HTRANS_NONSEQ && rem_load > 4'd1) begin
            rem_d   = rem_load;
            state_d = ST_BURST;
          end else begin
            arb = 1'b1;
          end
        end
      endcase
      if (arb) begin
        state_d = ST_ARB;
        if (hlock[owner_q]) begin
          state_d = ST_LOCKED;
        end else if (pick_valid) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          grant_d = pick_gnt;
        end else begin
          owner_d = IW'(DEFAULT_MASTER);
          grant_d = NUM_MASTERS'(1) << DEFAULT_MASTER;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q   <= ST_ARB;
      rem_q     <= '0;
      split_q   <= '0;
      owner_q   <= IW'(DEFAULT_MASTER);
      last_q    <= IW'(DEFAULT_MASTER);
      hgrant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster   <= 4'(DEFAULT_MASTER);
      hmastlock <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      split_q <= split_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hgrant  <= grant_d;
      if (hready) begin
        hmaster   <= 4'(owner_q);
        hmastlock <= hlock[owner_q];
      end
    end
  end

endmodule
